// File: rtl/divisor_pkg.sv
// Types and default sizes shared by the divider and its BCD conversion stages.
package divisor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        FIN
    } conv_state_t;

    localparam int unsigned TAMANYO = 32;
    localparam int unsigned DIGITOS = 10;
    localparam int unsigned T_MOD   = 6;

endpackage

// File: rtl/conversor_bcd_if.sv
// Start/Done request bus between a result producer and a BCD conversion stage.
interface conversor_bcd_if #(
    parameter int unsigned tamanyo = divisor_pkg::TAMANYO,
    parameter int unsigned digitos = divisor_pkg::DIGITOS
);

    logic                   Start;
    logic [tamanyo-1:0]     Valor;
    logic [4*digitos-1:0]   BCD;
    logic                   Signo;
    logic                   Busy;
    logic                   Done;

    modport master (
        output Start,
        output Valor,
        input  BCD,
        input  Signo,
        input  Busy,
        input  Done
    );

    modport slave (
        input  Start,
        input  Valor,
        output BCD,
        output Signo,
        output Busy,
        output Done
    );

endinterface

// File: rtl/bcd_ajuste_digito.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more before it is doubled.
module bcd_ajuste_digito (
    input  logic [3:0] digito_i,
    output logic [3:0] digito_c_o
);

    assign digito_c_o = (digito_i >= 4'd5) ? (digito_i + 4'd3) : digito_i;

endmodule

// File: rtl/conversor_bcd.sv
// Sequential double-dabble converter, one input bit per clock, sign + packed BCD result.
// Define BCD_SIGNED_EN to treat Valor as two's complement and drive Signo.
module conversor_bcd
    import divisor_pkg::*;
#(
    parameter int unsigned tamanyo = TAMANYO,
    parameter int unsigned digitos = DIGITOS,
    parameter int unsigned t_mod   = T_MOD
) (
    input  logic             CLK,
    input  logic             RSTa,
    conversor_bcd_if.slave   bus
);

    localparam int unsigned     BCD_W    = 4 * digitos;
    localparam int unsigned     SHIFT_W  = BCD_W + tamanyo;
    localparam logic [t_mod-1:0] CONT_INI = t_mod'(tamanyo - 1);
    localparam logic [t_mod-1:0] CONT_UNO = t_mod'(1);

    conv_state_t          state_q, state_d;
    logic [BCD_W-1:0]     acc_q, acc_d;
    logic [BCD_W-1:0]     acc_adj;
    logic [tamanyo-1:0]   mag_q, mag_d;
    logic [tamanyo-1:0]   mag_carga;
    logic [t_mod-1:0]     cont_q, cont_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [SHIFT_W-1:0]   desplazado;

    // Add-3 correction applied to every accumulator digit each CONV cycle
    for (genvar g = 0; g < digitos; g++) begin : g_ajuste
        bcd_ajuste_digito u_ajuste (
            .digito_i   (acc_q[4*g +: 4]),
            .digito_c_o (acc_adj[4*g +: 4])
        );
    end

`ifdef BCD_SIGNED_EN
    localparam logic [tamanyo-1:0] MAG_UNO = tamanyo'(1);

    logic sgn_q, sgn_d;
    logic signo_q, signo_d;

    // The most negative word maps to 2^(tamanyo-1), which still fits unsigned
    assign mag_carga = bus.Valor[tamanyo-1] ? (~bus.Valor + MAG_UNO) : bus.Valor;

    always_comb begin
        sgn_d   = sgn_q;
        signo_d = signo_q;
        if (state_q == IDLE && bus.Start) begin
            sgn_d = bus.Valor[tamanyo-1];
        end
        if (state_q == FIN) begin
            signo_d = sgn_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTa) begin
            sgn_q   <= 1'b0;
            signo_q <= 1'b0;
        end else begin
            sgn_q   <= sgn_d;
            signo_q <= signo_d;
        end
    end

    assign bus.Signo = signo_q;
`else
    assign mag_carga = bus.Valor;
    assign bus.Signo = 1'b0;
`endif

    // Next state and datapath
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        mag_d      = mag_q;
        cont_d     = cont_q;
        bcd_d      = bcd_q;
        done_d     = 1'b0;
        desplazado = {acc_adj, mag_q} << 1;

        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    state_d = CONV;
                    mag_d   = mag_carga;
                    acc_d   = '0;
                    cont_d  = CONT_INI;
                end
            end
            CONV: begin
                acc_d  = desplazado[tamanyo +: BCD_W];
                mag_d  = desplazado[tamanyo-1:0];
                cont_d = cont_q - CONT_UNO;
                if (cont_q == '0) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                bcd_d   = acc_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RSTa) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mag_q   <= '0;
            cont_q  <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mag_q   <= mag_d;
            cont_q  <= cont_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.BCD  = bcd_q;
    assign bus.Busy = busy_q;
    assign bus.Done = done_q;

endmodule

// File: tb/tb_conversor_bcd.sv
// Self-checking bench for conversor_bcd: vector table, random values against a decimal model,
// and hand-written handshake, overlap and reset sequences. Expectations follow BCD_SIGNED_EN.
module tb_conversor_bcd;

    localparam int unsigned TAM = 32;
    localparam int unsigned DIG = 10;
    localparam int unsigned BW  = 4 * DIG;
    localparam int          LAT = TAM + 1;

    logic CLK = 1'b0;
    logic RSTa;

    conversor_bcd_if #(.tamanyo(TAM), .digitos(DIG)) ifc ();

    conversor_bcd #(.tamanyo(TAM), .digitos(DIG), .t_mod(6)) u_dut (
        .CLK  (CLK),
        .RSTa (RSTa),
        .bus  (ifc)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [TAM-1:0] valor;
        logic [BW-1:0]  bcd_u;
        logic           sgn_u;
        logic [BW-1:0]  bcd_s;
        logic           sgn_s;
    } vec_t;

    vec_t tabla[10];

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Decimal reference: magnitude by plain arithmetic, digits by repeated division by ten
    function automatic logic [BW-1:0] ref_bcd(input logic [TAM-1:0] v);
        longint unsigned m;
        logic [BW-1:0]   r;
        r = '0;
`ifdef BCD_SIGNED_EN
        m = v[TAM-1] ? ((64'd1 << TAM) - 64'(v)) : 64'(v);
`else
        m = 64'(v);
`endif
        for (int i = 0; i < int'(DIG); i++) begin
            r[4*i +: 4] = 4'(m % 64'd10);
            m = m / 64'd10;
        end
        return r;
    endfunction

    function automatic logic ref_sgn(input logic [TAM-1:0] v);
`ifdef BCD_SIGNED_EN
        return v[TAM-1];
`else
        return 1'b0 & v[0];
`endif
    endfunction

    // One conversion: Start for a single edge, then count cycles until Done (bounded)
    task automatic run_conv(input logic [TAM-1:0] v, output logic [BW-1:0] bcd,
                            output logic sgn, output int lat, output logic busy_at_done);
        @(negedge CLK);
        ifc.Start = 1'b1;
        ifc.Valor = v;
        @(negedge CLK);
        ifc.Start = 1'b0;
        ifc.Valor = $urandom;
        lat = 0;
        while (!ifc.Done && lat < 100) begin
            @(negedge CLK);
            lat++;
        end
        bcd = ifc.BCD;
        sgn = ifc.Signo;
        busy_at_done = ifc.Busy;
    endtask

    initial begin
        logic [BW-1:0]  bcd;
        logic           sgn;
        logic           busy_d;
        logic [TAM-1:0] v;
        int             lat;
        int             t1, t2, n, ndone;

        tabla[0] = '{32'd1234,        40'h00_0000_1234, 1'b0, 40'h00_0000_1234, 1'b0};
        tabla[1] = '{32'hFFFF_FFF9,   40'h42_9496_7289, 1'b0, 40'h00_0000_0007, 1'b1};
        tabla[2] = '{32'h8000_0000,   40'h21_4748_3648, 1'b0, 40'h21_4748_3648, 1'b1};
        tabla[3] = '{32'hFFFF_FFFF,   40'h42_9496_7295, 1'b0, 40'h00_0000_0001, 1'b1};
        tabla[4] = '{32'd0,           40'h00_0000_0000, 1'b0, 40'h00_0000_0000, 1'b0};
        tabla[5] = '{32'd99,          40'h00_0000_0099, 1'b0, 40'h00_0000_0099, 1'b0};
        tabla[6] = '{32'd9,           40'h00_0000_0009, 1'b0, 40'h00_0000_0009, 1'b0};
        tabla[7] = '{32'd10,          40'h00_0000_0010, 1'b0, 40'h00_0000_0010, 1'b0};
        tabla[8] = '{32'd999_999_999, 40'h09_9999_9999, 1'b0, 40'h09_9999_9999, 1'b0};
        tabla[9] = '{32'h7FFF_FFFF,   40'h21_4748_3647, 1'b0, 40'h21_4748_3647, 1'b0};

        ifc.Start = 1'b0;
        ifc.Valor = '0;
        RSTa      = 1'b0;
        repeat (3) @(negedge CLK);
        check_val("reset_bcd",   64'(ifc.BCD),   64'd0);
        check_val("reset_signo", 64'(ifc.Signo), 64'd0);
        check_val("reset_busy",  64'(ifc.Busy),  64'd0);
        check_val("reset_done",  64'(ifc.Done),  64'd0);
        RSTa = 1'b1;

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            run_conv(tabla[i].valor, bcd, sgn, lat, busy_d);
            check_val("tab_latency", 64'(lat), 64'(LAT));
`ifdef BCD_SIGNED_EN
            check_val("tab_bcd",   64'(bcd), 64'(tabla[i].bcd_s));
            check_val("tab_signo", 64'(sgn), 64'(tabla[i].sgn_s));
`else
            check_val("tab_bcd",   64'(bcd), 64'(tabla[i].bcd_u));
            check_val("tab_signo", 64'(sgn), 64'(tabla[i].sgn_u));
`endif
            check_val("tab_busy_at_done", 64'(busy_d), 64'd0);
            @(negedge CLK);
            check_val("tab_done_pulse", 64'(ifc.Done), 64'd0);
            check_val("tab_bcd_hold",   64'(ifc.BCD),  64'(bcd));
        end

        // Random values against the decimal model
        for (int i = 0; i < 40; i++) begin
            v = (i % 4 == 0) ? TAM'($urandom_range(0, 9999)) : TAM'($urandom);
            run_conv(v, bcd, sgn, lat, busy_d);
            check_val("rnd_latency", 64'(lat), 64'(LAT));
            check_val("rnd_bcd",     64'(bcd), 64'(ref_bcd(v)));
            check_val("rnd_signo",   64'(sgn), 64'(ref_sgn(v)));
        end

        // Start held high: back-to-back conversions every TAM+2 cycles
        @(negedge CLK);
        ifc.Start = 1'b1;
        ifc.Valor = 32'd555;
        n = 0; t1 = -1; t2 = -1;
        while (t2 < 0 && n < 200) begin
            @(negedge CLK);
            n++;
            if (ifc.Done) begin
                if (t1 < 0) t1 = n;
                else begin
                    t2 = n;
                    ifc.Start = 1'b0;
                end
            end
        end
        ifc.Start = 1'b0;
        check_val("b2b_period", 64'(t2 - t1), 64'(TAM + 2));
        check_val("b2b_bcd",    64'(ifc.BCD), 64'(ref_bcd(32'd555)));
        ndone = 0;
        repeat (50) begin
            @(negedge CLK);
            if (ifc.Done) ndone++;
        end
        check_val("b2b_no_extra", 64'(ndone), 64'd0);

        // Start pulse during CONV is dropped
        @(negedge CLK);
        ifc.Start = 1'b1;
        ifc.Valor = 32'd99;
        @(negedge CLK);
        ifc.Start = 1'b0;
        repeat (4) @(negedge CLK);
        check_val("ovl_busy_conv", 64'(ifc.Busy), 64'd1);
        ifc.Start = 1'b1;
        ifc.Valor = 32'd5;
        @(negedge CLK);
        ifc.Start = 1'b0;
        ndone = 0;
        bcd   = '0;
        repeat (90) begin
            @(negedge CLK);
            if (ifc.Done) begin
                ndone++;
                if (ndone == 1) bcd = ifc.BCD;
            end
        end
        check_val("ovl_done_count", 64'(ndone), 64'd1);
        check_val("ovl_bcd",        64'(bcd),   64'h00_0000_0099);

        // Reset in the middle of a conversion
        @(negedge CLK);
        ifc.Start = 1'b1;
        ifc.Valor = 32'd777;
        @(negedge CLK);
        ifc.Start = 1'b0;
        repeat (9) @(negedge CLK);
        RSTa = 1'b0;
        @(negedge CLK);
        RSTa = 1'b1;
        check_val("rst_mid_bcd",   64'(ifc.BCD),   64'd0);
        check_val("rst_mid_signo", 64'(ifc.Signo), 64'd0);
        check_val("rst_mid_busy",  64'(ifc.Busy),  64'd0);
        ndone = 0;
        repeat (50) begin
            @(negedge CLK);
            if (ifc.Done) ndone++;
        end
        check_val("rst_mid_no_done", 64'(ndone), 64'd0);
        run_conv(32'd42, bcd, sgn, lat, busy_d);
        check_val("rst_after_latency", 64'(lat), 64'(LAT));
        check_val("rst_after_bcd",     64'(bcd), 64'h00_0000_0042);
        check_val("rst_after_signo",   64'(sgn), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
